pio_in_edge_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO: samples WIDTH external input pins, synchronises and

---
 rtl/pio_in_edge_irq.sv | 139 +++++++++++++
 tb/tb_pio_in_edge_irq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised, optionally debounced pins with sticky
// rising/falling edge capture and a maskable, registered level interrupt.
module pio_in_edge_irq #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_IRQ_MASK = 3'd1,
        REG_EDGE_CAP = 3'd2,
        REG_RISE_EN  = 3'd3,
        REG_FALL_EN  = 3'd4
    } reg_addr_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] mask_q, cap_q, rise_en_q, fall_en_q;
    logic [WIDTH-1:0] cap_d, rise, fall, clr, wd;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q;
    logic             wr;
    logic             unused_wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign deb = synced;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0]    cnt_q [WIDTH];
            logic [CW-1:0]    cnt_d [WIDTH];
            logic [WIDTH-1:0] deb_q, deb_d;

            // Counter only runs while the synced bit disagrees with the accepted
            // value; reaching the limit accepts the new level and restarts from 0.
            always_comb begin
                deb_d = deb_q;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (synced[i] != deb_q[i]) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = synced[i];
                        else                                    cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    deb_q <= '0;
                    for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    deb_q <= deb_d;
                    for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    assign wr        = chipselect & write;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // A new edge overrides a same-cycle W1C clear of that bit.
    always_comb begin
        rise  = deb & ~deb_prev_q & rise_en_q;
        fall  = ~deb & deb_prev_q & fall_en_q;
        clr   = (wr && address == REG_EDGE_CAP) ? wd : '0;
        cap_d = (cap_q & ~clr) | rise | fall;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (chipselect) begin
            case (address)
                REG_DATA:     readdata_d = 32'(deb);
                REG_IRQ_MASK: readdata_d = 32'(mask_q);
                REG_EDGE_CAP: readdata_d = 32'(cap_q);
                REG_RISE_EN:  readdata_d = 32'(rise_en_q);
                REG_FALL_EN:  readdata_d = 32'(fall_en_q);
                default:      readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_prev_q <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= |(cap_q & mask_q);
            if (wr) begin
                case (address)
                    REG_IRQ_MASK: mask_q    <= wd;
                    REG_RISE_EN:  rise_en_q <= wd;
                    REG_FALL_EN:  fall_en_q <= wd;
                    default:      ;
                endcase
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: one instance without debounce, one with a 4-cycle debouncer.
module tb_pio_in_edge_irq;

    logic        clk;
    logic        rst   [2];
    logic [2:0]  addr  [2];
    logic        cs    [2];
    logic        we    [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  pin   [2];
    logic        irq   [2];

    int checks = 0;
    int errors = 0;

    pio_in_edge_irq #(.WIDTH(2), .DEBOUNCE_CYCLES(0), .SYNC_STAGES(2)) u_deb0 (
        .clk(clk), .reset(rst[0]), .address(addr[0]), .chipselect(cs[0]), .write(we[0]),
        .writedata(wdata[0]), .readdata(rdata[0]), .in_port(pin[0]), .irq(irq[0])
    );

    pio_in_edge_irq #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) u_deb4 (
        .clk(clk), .reset(rst[1]), .address(addr[1]), .chipselect(cs[1]), .write(we[1]),
        .writedata(wdata[1]), .readdata(rdata[1]), .in_port(pin[1]), .irq(irq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_wr(input int d, input logic [2:0] a, input logic [31:0] v);
        cs[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wdata[d] = v;
        tick();
        cs[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic bus_rd(input int d, input logic [2:0] a, output logic [31:0] v);
        cs[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
        tick();
        v = rdata[d];
        cs[d] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cs[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; pin[d] = '0;
        end
        ticks(2);
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdata[d] !== 32'd0) begin errors++; $display("FAIL reset_readdata[%0d] got %h exp 0", d, rdata[d]); end
            checks++;
            if (irq[d] !== 1'b0) begin errors++; $display("FAIL reset_irq[%0d] got %b exp 0", d, irq[d]); end
            bus_rd(d, 3'd3, v);
            checks++;
            if (v !== 32'h3) begin errors++; $display("FAIL reset_rise_en[%0d] got %h exp 3", d, v); end
            bus_wr(d, 3'd6, 32'hFFFF_FFFF);
            bus_rd(d, 3'd6, v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL unmapped_read[%0d] got %h exp 0", d, v); end
        end
    endtask

    task automatic test_data_latency();
        logic [31:0] v;
        cs[0] = 1'b1; addr[0] = 3'd0;
        pin[0] = 2'b10;
        ticks(2);
        checks++;
        if (rdata[0] !== 32'd0) begin errors++; $display("FAIL data_early got %h exp 0", rdata[0]); end
        tick();
        checks++;
        if (rdata[0] !== 32'd2) begin errors++; $display("FAIL data_latency3 got %h exp 2", rdata[0]); end
        cs[0] = 1'b0;
        ticks(2);
        bus_rd(0, 3'd2, v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL edge_cap_rise got %h exp 2", v); end
        checks++;
        if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq[0]); end
    endtask

    task automatic test_irq_w1c();
        logic [31:0] v;
        bus_wr(0, 3'd2, 32'h3);
        bus_wr(0, 3'd1, 32'h2);
        pin[0] = 2'b00;
        ticks(4);
        pin[0] = 2'b10;
        ticks(3);
        checks++;
        if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq[0]); end
        tick();
        checks++;
        if (irq[0] !== 1'b1) begin errors++; $display("FAIL irq_assert got %b exp 1", irq[0]); end
        bus_wr(0, 3'd2, 32'h2);
        checks++;
        if (rdata[0] !== 32'd2) begin errors++; $display("FAIL cap_read_prewrite got %h exp 2", rdata[0]); end
        checks++;
        if (irq[0] !== 1'b1) begin errors++; $display("FAIL irq_hold_on_clear got %b exp 1", irq[0]); end
        tick();
        checks++;
        if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_deassert got %b exp 0", irq[0]); end
        bus_rd(0, 3'd2, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL cap_cleared got %h exp 0", v); end
    endtask

    task automatic test_w1c_vs_edge();
        logic [31:0] v;
        bus_wr(0, 3'd1, 32'h1);
        pin[0] = 2'b00;
        ticks(4);
        bus_wr(0, 3'd2, 32'h3);
        pin[0] = 2'b01;
        ticks(5);
        pin[0] = 2'b00;
        ticks(4);
        pin[0] = 2'b01;
        ticks(2);
        bus_wr(0, 3'd2, 32'h1);
        checks++;
        if (irq[0] !== 1'b1) begin errors++; $display("FAIL race_irq0 got %b exp 1", irq[0]); end
        tick();
        checks++;
        if (irq[0] !== 1'b1) begin errors++; $display("FAIL race_irq1 got %b exp 1", irq[0]); end
        bus_rd(0, 3'd2, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL race_edge_wins got %h exp 1", v); end
        bus_wr(0, 3'd2, 32'h1);
        bus_rd(0, 3'd2, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL plain_clear got %h exp 0", v); end
    endtask

    task automatic test_fall_only();
        logic [31:0] v;
        bus_wr(0, 3'd3, 32'h0);
        bus_wr(0, 3'd4, 32'h1);
        pin[0] = 2'b00;
        ticks(5);
        bus_wr(0, 3'd2, 32'h3);
        pin[0] = 2'b01;
        ticks(5);
        bus_rd(0, 3'd2, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL fall_only_rise got %h exp 0", v); end
        pin[0] = 2'b00;
        ticks(5);
        bus_rd(0, 3'd2, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL fall_only_fall got %h exp 1", v); end
        bus_wr(0, 3'd3, 32'h0);
        bus_rd(0, 3'd2, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL en_change_keeps_cap got %h exp 1", v); end
        bus_wr(0, 3'd3, 32'h3);
        bus_wr(0, 3'd4, 32'h0);
        bus_wr(0, 3'd1, 32'h0);
        bus_wr(0, 3'd2, 32'h3);
    endtask

    task automatic test_debounce();
        logic [31:0] v;
        logic [31:0] seen;
        pin[1] = 2'b00;
        ticks(10);
        cs[1] = 1'b1; addr[1] = 3'd0;
        pin[1] = 2'b01;
        ticks(6);
        checks++;
        if (rdata[1] !== 32'd0) begin errors++; $display("FAIL deb_early got %h exp 0", rdata[1]); end
        tick();
        checks++;
        if (rdata[1] !== 32'd1) begin errors++; $display("FAIL deb_latency7 got %h exp 1", rdata[1]); end
        cs[1] = 1'b0;
        pin[1] = 2'b00;
        ticks(12);
        bus_wr(1, 3'd2, 32'h3);
        for (int len = 3; len <= 5; len += 2) begin
            seen = '0;
            cs[1] = 1'b1; addr[1] = 3'd0;
            pin[1] = 2'b01;
            repeat (len) begin tick(); seen |= rdata[1]; end
            pin[1] = 2'b00;
            repeat (12) begin tick(); seen |= rdata[1]; end
            cs[1] = 1'b0;
            bus_rd(1, 3'd2, v);
            checks++;
            if (seen !== ((len >= 4) ? 32'd1 : 32'd0))
                begin errors++; $display("FAIL pulse%0d_data got %h exp %0d", len, seen, (len >= 4)); end
            checks++;
            if (v !== ((len >= 4) ? 32'd1 : 32'd0))
                begin errors++; $display("FAIL pulse%0d_cap got %h exp %0d", len, v, (len >= 4)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_wr(1, 3'd1, 32'h3);
        bus_wr(1, 3'd4, 32'h3);
        bus_wr(1, 3'd3, 32'h0);
        ticks(2);
        checks++;
        if (irq[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b exp 1", irq[1]); end
        pin[1] = 2'b01;
        ticks(4);
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        checks++;
        if (irq[1] !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b exp 0", irq[1]); end
        checks++;
        if (rdata[1] !== 32'd0) begin errors++; $display("FAIL mid_reset_readdata got %h exp 0", rdata[1]); end
        bus_rd(1, 3'd0, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_data got %h exp 0", v); end
        bus_rd(1, 3'd2, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_cap got %h exp 0", v); end
        bus_rd(1, 3'd1, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_mask got %h exp 0", v); end
        bus_rd(1, 3'd3, v);
        checks++;
        if (v !== 32'd3) begin errors++; $display("FAIL mid_reset_rise got %h exp 3", v); end
        bus_rd(1, 3'd4, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_fall got %h exp 0", v); end
        ticks(12);
        bus_rd(1, 3'd2, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL post_reset_edge got %h exp 1", v); end
        bus_rd(1, 3'd0, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL post_reset_data got %h exp 1", v); end
    endtask

    // Model works on settled pin levels: each accepted level change contributes
    // its enabled rise/fall bits; W1C clears apply before the following change.
    task automatic test_random(input int d);
        logic [31:0] v, w;
        logic [1:0]  pin_m, cap_m, mask_m, rise_m, fall_m, clr, newp;
        logic        irq_m;
        pin_m = pin[d];
        ticks(15);
        bus_wr(d, 3'd2, 32'h3);
        cap_m = '0; mask_m = '0; rise_m = 2'b11; fall_m = '0;
        bus_wr(d, 3'd1, 32'h0); bus_wr(d, 3'd3, 32'h3); bus_wr(d, 3'd4, 32'h0);
        for (int it = 0; it < 20; it++) begin
            rise_m = 2'($urandom_range(0, 3));
            w = $urandom; w[1:0] = rise_m; bus_wr(d, 3'd3, w);
            fall_m = 2'($urandom_range(0, 3));
            w = $urandom; w[1:0] = fall_m; bus_wr(d, 3'd4, w);
            mask_m = 2'($urandom_range(0, 3));
            w = $urandom; w[1:0] = mask_m; bus_wr(d, 3'd1, w);
            clr = 2'($urandom_range(0, 3));
            bus_wr(d, 3'd2, {30'd0, clr});
            cap_m = cap_m & ~clr;
            newp = 2'($urandom_range(0, 3));
            pin[d] = newp;
            ticks(12);
            for (int b = 0; b < 2; b++) begin
                if (newp[b] && !pin_m[b] && rise_m[b]) cap_m[b] = 1'b1;
                if (!newp[b] && pin_m[b] && fall_m[b]) cap_m[b] = 1'b1;
            end
            pin_m = newp;
            irq_m = (cap_m & mask_m) != 2'b00;
            bus_rd(d, 3'd0, v);
            checks++;
            if (v !== {30'd0, pin_m}) begin errors++; $display("FAIL rnd%0d_data it%0d got %h exp %h", d, it, v, pin_m); end
            bus_rd(d, 3'd2, v);
            checks++;
            if (v !== {30'd0, cap_m}) begin errors++; $display("FAIL rnd%0d_cap it%0d got %h exp %h", d, it, v, cap_m); end
            bus_rd(d, 3'd1, v);
            checks++;
            if (v !== {30'd0, mask_m}) begin errors++; $display("FAIL rnd%0d_mask it%0d got %h exp %h", d, it, v, mask_m); end
            checks++;
            if (irq[d] !== irq_m) begin errors++; $display("FAIL rnd%0d_irq it%0d got %b exp %b", d, it, irq[d], irq_m); end
        end
    endtask

    initial begin
        test_reset();
        test_data_latency();
        test_irq_w1c();
        test_w1c_vs_edge();
        test_fall_only();
        test_debounce();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
